// File: rtl/operand_sequencer_nbits.sv
// operand_sequencer_nbits
//   Serial operand front end and result back end for a combinational N-bit
//   modulo unit. Operand A then operand B are accepted over a valid/ready
//   port and held in registers that drive the unit. One cycle later the
//   result and {neg,zr,cry,of} flags are captured and offered on a
//   valid/ready output port until the consumer takes them.
//
//   Optional feature macro: OPSEQ_STICKY_ERR_EN
//     defined   -> err_sticky latches when a captured result reports of,
//                  clr_err clears it (a simultaneous set takes priority).
//     undefined -> err_sticky is tied low and clr_err is ignored.

module operand_sequencer_nbits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic         busy,
  output logic         err_sticky,
  input  logic         clr_err
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t         state_q;
  logic [N-1:0]   alu_a_q;
  logic [N-1:0]   alu_b_q;
  logic [N-1:0]   out_result_q;
  logic [3:0]     out_flags_q;
  logic           out_valid_q;

  // The unit's outputs are sampled during S_EXEC, once both operands have
  // been stable on alu_a/alu_b for a full cycle.
  logic           capture;
  assign capture = (state_q == S_EXEC);

  // Operand acceptance is only possible while collecting A or B; in_data is
  // never looked at in the other two states.
  assign in_ready = (state_q == S_A) || (state_q == S_B);
  assign busy     = (state_q != S_A);

  // Sequencer FSM: collect A, collect B, capture result, hold until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (in_valid) begin
            alu_a_q <= in_data;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (in_valid) begin
            alu_b_q <= in_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_result_q <= alu_result;
          out_flags_q  <= alu_flags;
          out_valid_q  <= 1'b1;
          state_q      <= S_HOLD;
        end
        S_HOLD: begin
          // Result registers are left untouched so the last value stays
          // visible after the handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_A;
          end
        end
        default: begin
          state_q <= S_A;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_valid  = out_valid_q;

`ifdef OPSEQ_STICKY_ERR_EN
  logic err_q;
  logic err_d;

  // Set on an overflow capture has priority over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (capture && alu_flags[0]) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = clr_err | capture;
  assign err_sticky        = 1'b0;
`endif

endmodule
